booth_arbiter: RTL
==================

Name: booth_arbiter

Overview:
Shares one Booth multiplier controller/datapath between N_REQ independent requesters. It arbitrates round-robin, latches the winner's operands, and drives the multiplier's Request/Done handshake. It then captures the product and returns it with a one-cycle ack. The block sits between client blocks and the multiplier, and it is the only agent that drives the multiplier's Request.

Parameters:
N_LEN, 8, operand width in bits (signed two's complement); product is 2*N_LEN bits.
N_REQ, 4, number of requesters (2..8); index width RW = $clog2(N_REQ).

Ports:
Clock  input  1  system clock, rising edge.
nReset  input  1  asynchronous, active-low reset.
req  input  N_REQ  per-requester request level; held high until matching ack.
op_a  input  N_REQ*N_LEN  multiplicands; requester i uses bits [i*N_LEN +: N_LEN].
op_b  input  N_REQ*N_LEN  multipliers; requester i uses bits [i*N_LEN +: N_LEN].
ack  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
result  output  2*N_LEN  signed product; valid while ack is high, held afterwards.
grant_id  output  RW  index of the current/last granted requester.
busy  output  1  high whenever the FSM is not in IDLE.
mul_request  output  1  Request to the multiplier.
mul_a  output  N_LEN  latched multiplicand to the multiplier.
mul_b  output  N_LEN  latched multiplier to the multiplier.
mul_done  input  1  multiplier Done (high while the multiplier is idle).
mul_product  input  2*N_LEN  multiplier product.

Behaviour:
- Reset (async, nReset low):
  - FSM = IDLE; ack = 0, result = 0, mul_request = 0, mul_a = mul_b = 0, busy = 0.
  - grant_id = 0; round-robin pointer last = N_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESPOND.
- IDLE:
  - If any req bit is set and mul_done = 1, pick the first set bit searching from (last+1) mod N_REQ upward with wrap.
  - On that edge: latch that requester's op_a/op_b into mul_a/mul_b, set grant_id and last to the winner, go to ISSUE.
  - If mul_done = 0, stay in IDLE (multiplier not idle).
- ISSUE: mul_request = 1 for exactly this cycle; go to WAIT_START.
- WAIT_START: wait for mul_done = 0, which confirms the multiplier has left its idle state; then go to WAIT_DONE.
- WAIT_DONE:
  - When mul_done = 1: capture mul_product into result on that edge, go to RESPOND.
- RESPOND:
  - ack[grant_id] = 1 for one cycle, all other ack bits 0; go to IDLE.
  - The requester drops req on the same edge it samples ack.
- mul_request, ack and busy are decoded combinationally from state (registered state, no glitch paths from inputs).
- Operands are sampled only in the IDLE->ISSUE transition. Later changes to op_a/op_b or req have no effect on the current operation.
- req dropped mid-operation: the operation still completes, and ack is still pulsed (the requester may ignore it). No abort.
- Requests arriving while busy wait; no request is lost while held high.
- Fairness: with all req held high, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 operations.
- A single requester re-requesting immediately is granted again if no other req is set. Its earliest re-grant is the IDLE cycle after RESPOND.
- Latency from grant edge to ack = 1 (ISSUE) + 1 (WAIT_START) + multiplier busy time + 1 (RESPOND). Multiplier busy time is N_LEN shifts + up to N_LEN add/sub + 1 prep cycle.
- result holds its last value until the next capture.
- Reset mid-operation: everything returns to its reset state immediately. The multiplier shares nReset, so no stale handshake remains.

Test Plan:
- Single request: req=0001, a0=3, b0=0xFE (-2) -> mul_request one pulse; ack=0001 once; result=0xFFFA (-6); grant_id=0.
- Extremes: a=0x80, b=0x80 (-128*-128) -> result=0x4000. Then a=0x7F, b=0x80 -> result=0xC080.
- Round-robin: req=1111 held, operands a_i=i+1, b_i=2 -> ack order 0,1,2,3,0; results 2,4,6,8. mul_request never asserts while busy.
- Late arrival: req=0001 in progress, req[2] rises mid-op, req[1] rises later -> after ack0, grant 1 (next after last=0), then 2. Operand change on req[1] after its grant does not alter its result.
- Dropped request: req[3] deasserted during WAIT_DONE -> operation completes, ack=1000 still pulses once, then IDLE with busy=0.
- Reset mid-op: nReset low during WAIT_DONE -> ack=0, busy=0, mul_request=0 immediately. After release, req=0010 gets grant_id=1 and a correct product.

Source files
------------

// File: rtl/booth_arbiter_if.sv
// booth_arbiter_if: bundles the requester-side and multiplier-side buses of booth_arbiter.
//   slave  modport: the arbiter (takes requests, drives the multiplier Request/operands).
//   master modport: the environment (requesters plus the Booth multiplier).
//   req/op_a/op_b/ack/result/grant_id/busy   requester side
//   mul_request/mul_a/mul_b/mul_done/mul_product   multiplier handshake
interface booth_arbiter_if #(
    parameter int unsigned N_LEN = 8,
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*N_LEN-1:0] op_a;
    logic [N_REQ*N_LEN-1:0] op_b;
    logic [N_REQ-1:0]       ack;
    logic [2*N_LEN-1:0]     result;
    logic [RW-1:0]          grant_id;
    logic                   busy;
    logic                   mul_request;
    logic [N_LEN-1:0]       mul_a;
    logic [N_LEN-1:0]       mul_b;
    logic                   mul_done;
    logic [2*N_LEN-1:0]     mul_product;

    modport slave (
        input  req, op_a, op_b, mul_done, mul_product,
        output ack, result, grant_id, busy, mul_request, mul_a, mul_b
    );

    modport master (
        output req, op_a, op_b, mul_done, mul_product,
        input  ack, result, grant_id, busy, mul_request, mul_a, mul_b
    );
endinterface

// File: rtl/booth_arbiter.sv
// booth_arbiter: shares one Booth multiplier between N_REQ requesters.
// Round-robin arbitration, operand latch, Request/Done handshake, product capture and a
// one-cycle one-hot ack back to the winner.
//   Clock   rising-edge system clock
//   nReset  asynchronous active-low reset
//   bus     booth_arbiter_if.slave (requester bus + multiplier handshake)
module booth_arbiter #(
    parameter int unsigned N_LEN = 8,
    parameter int unsigned N_REQ = 4
) (
    input logic               Clock,
    input logic               nReset,
    booth_arbiter_if.slave    bus
);
    localparam int unsigned RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone,
        StRespond
    } state_e;

    state_e               state_q, state_d;
    logic [RW-1:0]        last_q;
    logic [RW-1:0]        grant_q;
    logic [N_LEN-1:0]     mul_a_q;
    logic [N_LEN-1:0]     mul_b_q;
    logic [2*N_LEN-1:0]   result_q;

    logic                 pick_valid;
    logic [RW-1:0]        pick_id;
    logic                 load;
    logic                 capture;

    // Round-robin search. Offsets are walked from farthest to nearest so the last hit
    // written is the nearest set bit after last_q.
    always_comb begin : rr_search
        logic [RW-1:0] idx;
        idx        = '0;
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = RW'((32'(last_q) + 32'(k)) % N_REQ);
            if (bus.req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    // Next-state logic; the arbiter only issues while the multiplier reports idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (pick_valid && bus.mul_done) state_d = StIssue;
            StIssue:     state_d = StWaitStart;
            StWaitStart: if (!bus.mul_done) state_d = StWaitDone;
            StWaitDone:  if (bus.mul_done) state_d = StRespond;
            StRespond:   state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    assign load    = (state_q == StIdle) && pick_valid && bus.mul_done;
    assign capture = (state_q == StWaitDone) && bus.mul_done;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= StIdle;
            last_q   <= RW'(N_REQ - 1);
            grant_q  <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                last_q  <= pick_id;
                grant_q <= pick_id;
                mul_a_q <= bus.op_a[32'(pick_id)*N_LEN +: N_LEN];
                mul_b_q <= bus.op_b[32'(pick_id)*N_LEN +: N_LEN];
            end
            if (capture) begin
                result_q <= bus.mul_product;
            end
        end
    end

    // Handshake outputs decode registered state only.
    assign bus.mul_request = (state_q == StIssue);
    assign bus.busy        = (state_q != StIdle);
    assign bus.ack         = (state_q == StRespond) ? (N_REQ'(1) << grant_q) : '0;
    assign bus.grant_id    = grant_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.result      = result_q;
endmodule
